// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int ROB_INDEX_BIT = 4;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef struct packed {
    logic [ROB_INDEX_BIT-1:0] robId;
    logic [31:0]              result;
  } cdb_entry_t;

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSB = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and the broadcast bus of the CDB arbiter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                     alu_valid;
  logic [ROB_INDEX_BIT-1:0] alu_rob_id;
  logic [31:0]              alu_result;
  logic                     alu_ready_out;

  logic                     lsb_valid;
  logic [ROB_INDEX_BIT-1:0] lsb_rob_id;
  logic [31:0]              lsb_result;
  logic                     lsb_ready_out;

  logic                     cdb_valid_out;
  logic [ROB_INDEX_BIT-1:0] cdb_rob_id_out;
  logic [31:0]              cdb_val_out;
  logic                     cdb_src_out;

  modport slave (
    input  alu_valid, alu_rob_id, alu_result,
    input  lsb_valid, lsb_rob_id, lsb_result,
    output alu_ready_out, lsb_ready_out,
    output cdb_valid_out, cdb_rob_id_out, cdb_val_out, cdb_src_out
  );

  modport master (
    output alu_valid, alu_rob_id, alu_result,
    output lsb_valid, lsb_rob_id, lsb_result,
    input  alu_ready_out, lsb_ready_out,
    input  cdb_valid_out, cdb_rob_id_out, cdb_val_out, cdb_src_out
  );

endinterface

// File: rtl/cdb_fifo.sv
// Small power-of-two FIFO buffering one producer's results ahead of the CDB.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] wdata_in,
  output logic [CW-1:0]    count_out,
  output logic [WIDTH-1:0] head_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Occupancy after this edge; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push_in && !pop_in) begin
      count_d = count_q + CW'(1);
    end else if (!push_in && pop_in) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush empties the queue.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (flush_in) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_in) begin
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (pop_in) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; the count decides what is meaningful.
  always_ff @(posedge clk_in) begin
    if (push_in && !flush_in) begin
      mem_q[wrPtr_q] <= wdata_in;
    end
  end

  assign count_out = count_q;
  assign head_out  = mem_q[rdPtr_q];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting one ALU or LSB result onto the CDB per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          clear_in,
  cdb_arbiter_if.slave  bus,
  output logic [31:0]   conflict_cnt_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  cdb_entry_t aluIn, lsbIn, aluHead, lsbHead;
  logic [CW-1:0] aluCount, lsbCount;
  logic aluPush, lsbPush, aluBusy, lsbBusy, advance, grantAlu, grantLsb;

  logic                     cdbValid_q, cdbValid_d;
  logic [ROB_INDEX_BIT-1:0] cdbRobId_q, cdbRobId_d;
  logic [31:0]              cdbVal_q, cdbVal_d;
  logic                     cdbSrc_q, cdbSrc_d;
  rr_ptr_e                  rrPtr_q, rrPtr_d;
  logic [31:0]              conflictCnt_q, conflictCnt_d;

  assign aluIn = {bus.alu_rob_id, bus.alu_result};
  assign lsbIn = {bus.lsb_rob_id, bus.lsb_result};

  assign bus.alu_ready_out = rdy_in && (aluCount < FULL);
  assign bus.lsb_ready_out = rdy_in && (lsbCount < FULL);

  assign advance  = rdy_in && !clear_in;
  assign aluPush  = advance && bus.alu_valid && bus.alu_ready_out;
  assign lsbPush  = advance && bus.lsb_valid && bus.lsb_ready_out;
  assign aluBusy  = (aluCount != '0);
  assign lsbBusy  = (lsbCount != '0);
  assign grantAlu = advance && aluBusy && (!lsbBusy || rrPtr_q == RR_ALU);
  assign grantLsb = advance && lsbBusy && (!aluBusy || rrPtr_q == RR_LSB);

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cdb_entry_t))) aluFifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (aluPush),
    .pop_in   (grantAlu),
    .flush_in (clear_in),
    .wdata_in (aluIn),
    .count_out(aluCount),
    .head_out (aluHead)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(cdb_entry_t))) lsbFifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (lsbPush),
    .pop_in   (grantLsb),
    .flush_in (clear_in),
    .wdata_in (lsbIn),
    .count_out(lsbCount),
    .head_out (lsbHead)
  );

  // Next broadcast, pointer and contention count; clear wins over a paused pipeline.
  always_comb begin
    cdbValid_d    = cdbValid_q;
    cdbRobId_d    = cdbRobId_q;
    cdbVal_d      = cdbVal_q;
    cdbSrc_d      = cdbSrc_q;
    rrPtr_d       = rrPtr_q;
    conflictCnt_d = conflictCnt_q;
    if (clear_in) begin
      cdbValid_d = 1'b0;
      rrPtr_d    = RR_ALU;
    end else if (rdy_in) begin
      if (grantAlu) begin
        cdbValid_d = 1'b1;
        cdbRobId_d = aluHead.robId;
        cdbVal_d   = aluHead.result;
        cdbSrc_d   = CDB_SRC_ALU;
      end else if (grantLsb) begin
        cdbValid_d = 1'b1;
        cdbRobId_d = lsbHead.robId;
        cdbVal_d   = lsbHead.result;
        cdbSrc_d   = CDB_SRC_LSB;
      end else begin
        cdbValid_d = 1'b0;
      end
      if (aluBusy && lsbBusy) begin
        rrPtr_d       = (rrPtr_q == RR_ALU) ? RR_LSB : RR_ALU;
        conflictCnt_d = conflictCnt_q + 32'd1;
      end
    end
  end

  // Registered broadcast outputs and arbitration state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdbValid_q    <= 1'b0;
      cdbRobId_q    <= '0;
      cdbVal_q      <= '0;
      cdbSrc_q      <= CDB_SRC_ALU;
      rrPtr_q       <= RR_ALU;
      conflictCnt_q <= '0;
    end else begin
      cdbValid_q    <= cdbValid_d;
      cdbRobId_q    <= cdbRobId_d;
      cdbVal_q      <= cdbVal_d;
      cdbSrc_q      <= cdbSrc_d;
      rrPtr_q       <= rrPtr_d;
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign bus.cdb_valid_out  = cdbValid_q;
  assign bus.cdb_rob_id_out = cdbRobId_q;
  assign bus.cdb_val_out    = cdbVal_q;
  assign bus.cdb_src_out    = cdbSrc_q;
  assign conflict_cnt_out   = conflictCnt_q;

endmodule
